// File: rtl/alu_seq.sv
// alu_seq: multi-cycle XOR/ADD/SUB/MUL ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Latency: 1 cycle for XOR/ADD/SUB, WIDTH step edges after accept for MUL; result held in DONE until out_ready.
// Optional flags (carry/ovf/zero) are built when macro ALU_SEQ_FLAGS_EN is defined.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       opALU,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Rout,
    output logic [WIDTH-1:0] Rhi,
    output logic             busy
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             carry,
    output logic             ovf,
    output logic             zero
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 accept, last_step, sub_c;
    logic [WIDTH-1:0]     bop, sum;

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign last_step = (state_q == S_MUL) && (cnt_q == CNT_W'(WIDTH - 1));
    assign sub_c     = (opALU == 2'd3);
    assign bop       = sub_c ? ~B : B;

`ifdef ALU_SEQ_FLAGS_EN
    logic [WIDTH:0] sum_w;
    logic           carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
    assign sum_w = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, sub_c};
    assign sum   = sum_w[WIDTH-1:0];
    assign carry = carry_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;
`else
    assign sum = A + bop + {{(WIDTH-1){1'b0}}, sub_c};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
`ifdef ALU_SEQ_FLAGS_EN
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = (opALU == 2'd2) ? S_MUL : S_DONE;
            S_MUL:  if (last_step) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Multiplicand shifts left and multiplier shifts right, so each step only looks at b_q[0].
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
`ifdef ALU_SEQ_FLAGS_EN
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
`endif
        if (accept) begin
            a_d   = {{WIDTH{1'b0}}, A};
            b_d   = B;
            cnt_d = '0;
            case (opALU)
                2'd0:    acc_d = {{WIDTH{1'b0}}, A ^ B};
                2'd2:    acc_d = '0;
                default: acc_d = {{WIDTH{1'b0}}, sum};
            endcase
`ifdef ALU_SEQ_FLAGS_EN
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            zero_d  = (acc_d == '0);
            if (opALU == 2'd1 || opALU == 2'd3) begin
                carry_d = sum_w[WIDTH];
                ovf_d   = (A[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            if (opALU == 2'd2) zero_d = 1'b0;
`endif
        end else if (state_q == S_MUL) begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
`ifdef ALU_SEQ_FLAGS_EN
            if (last_step) begin
                carry_d = (acc_d[2*WIDTH-1:WIDTH] != '0);
                ovf_d   = (acc_d[2*WIDTH-1:WIDTH] != '0);
                zero_d  = (acc_d == '0);
            end
`endif
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    assign Rout = acc_q[WIDTH-1:0];
    assign Rhi  = acc_q[2*WIDTH-1:WIDTH];
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: WIDTH=16 and WIDTH=8 instances, hand-computed expected results.
module tb_alu_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready, in_ready, out_valid, busy;
    logic [15:0] A, B, Rout, Rhi;
    logic [1:0]  op;
    logic        rst8_n, in_valid8, out_ready8, in_ready8, out_valid8, busy8;
    logic [7:0]  A8, B8, Rout8, Rhi8;
    logic [1:0]  op8;
`ifdef ALU_SEQ_FLAGS_EN
    logic carry, ovf, zero, carry8, ovf8, zero8;
`endif

    int checks = 0;
    int errors = 0;
    int steps;

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opALU(op), .out_valid(out_valid), .out_ready(out_ready),
        .Rout(Rout), .Rhi(Rhi), .busy(busy)
`ifdef ALU_SEQ_FLAGS_EN
        , .carry(carry), .ovf(ovf), .zero(zero)
`endif
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .opALU(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .Rout(Rout8), .Rhi(Rhi8), .busy(busy8)
`ifdef ALU_SEQ_FLAGS_EN
        , .carry(carry8), .ovf(ovf8), .zero(zero8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an op for one edge, then scramble the inputs to prove they were latched.
    task automatic issue16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        in_valid = 1'b0; op = 2'd1; A = 16'hDEAD; B = 16'hBEEF;
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        in_valid8 = 1'b1; op8 = o; A8 = a; B8 = b;
        @(negedge clk);
        in_valid8 = 1'b0; op8 = 2'd1; A8 = 8'h5A; B8 = 8'hC3;
    endtask

    // Counts edges after the accept edge until out_valid is seen; bounded.
    task automatic wait16(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic consume16();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; op = '0;
        rst8_n = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; A8 = '0; B8 = '0; op8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rout", Rout, 0);
        chk("rst_rhi", Rhi, 0);
        rst_n = 1'b1; rst8_n = 1'b1;

        // out_ready while idle does nothing
        consume16();
        chk("idle_ordy_in_ready", in_ready, 1);
        chk("idle_ordy_out_valid", out_valid, 0);

        issue16(2'd1, 16'hFFFF, 16'h0001);
        chk("add_valid_lat1", out_valid, 1);
        chk("add_rout", Rout, 16'h0000);
        chk("add_rhi", Rhi, 0);
        chk("add_in_ready", in_ready, 0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("add_carry", carry, 1);
        chk("add_zero", zero, 1);
        chk("add_ovf", ovf, 0);
`endif
        consume16();
        chk("add_cons_valid", out_valid, 0);
        chk("add_cons_in_ready", in_ready, 1);

        issue16(2'd3, 16'h0005, 16'h0007);
        chk("sub1_rout", Rout, 16'hFFFE);
`ifdef ALU_SEQ_FLAGS_EN
        chk("sub1_carry", carry, 0);
        chk("sub1_ovf", ovf, 0);
`endif
        consume16();

        issue16(2'd3, 16'h8000, 16'h0001);
        chk("sub2_rout", Rout, 16'h7FFF);
`ifdef ALU_SEQ_FLAGS_EN
        chk("sub2_ovf", ovf, 1);
        chk("sub2_carry", carry, 1);
`endif
        consume16();

        issue16(2'd0, 16'hA5A5, 16'h0FF0);
        chk("xor_rout", Rout, 16'hAA55);
        chk("xor_rhi", Rhi, 0);
        consume16();

        issue16(2'd2, 16'hFFFF, 16'hFFFF);
        chk("mul_in_ready", in_ready, 0);
        chk("mul_busy", busy, 1);
        chk("mul_no_valid", out_valid, 0);
        wait16(steps);
        chk("mul_steps", steps, 16);
        chk("mul_rhi", Rhi, 16'hFFFE);
        chk("mul_rout", Rout, 16'h0001);
        repeat (2) @(negedge clk);
        chk("mul_hold_busy", busy, 1);
        chk("mul_hold_in_ready", in_ready, 0);
        chk("mul_hold_rout", Rout, 16'h0001);
`ifdef ALU_SEQ_FLAGS_EN
        chk("mul_carry", carry, 1);
        chk("mul_ovf", ovf, 1);
        chk("mul_zero", zero, 0);
`endif
        consume16();
        chk("mul_cons_in_ready", in_ready, 1);

        // Backpressure with a competing in_valid that must be ignored
        issue16(2'd1, 16'h1234, 16'h1111);
        chk("bp_rout0", Rout, 16'h2345);
        in_valid = 1'b1; op = 2'd0; A = 16'hFFFF; B = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rout", Rout, 16'h2345);
            chk("bp_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        consume16();
        chk("bp_cons_valid", out_valid, 0);
        chk("bp_cons_in_ready", in_ready, 1);

        // Reset in the middle of a multiply
        issue16(2'd2, 16'hFFFF, 16'hFFFF);
        repeat (6) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_rout", Rout, 0);
        chk("mrst_rhi", Rhi, 0);

        issue16(2'd2, 16'h0003, 16'h0005);
        wait16(steps);
        chk("mul2_steps", steps, 16);
        chk("mul2_rout", Rout, 16'h000F);
        chk("mul2_rhi", Rhi, 0);
        consume16();

        // WIDTH=8 instance
        issue8(2'd2, 8'hFF, 8'h02);
        wait8(steps);
        chk("w8_mul_steps", steps, 8);
        chk("w8_mul_rhi", Rhi8, 8'h01);
        chk("w8_mul_rout", Rout8, 8'hFE);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        chk("w8_in_ready", in_ready8, 1);
        issue8(2'd1, 8'h80, 8'h80);
        chk("w8_add_valid", out_valid8, 1);
        chk("w8_add_rout", Rout8, 8'h00);
`ifdef ALU_SEQ_FLAGS_EN
        chk("w8_add_ovf", ovf8, 1);
        chk("w8_add_carry", carry8, 1);
        chk("w8_add_zero", zero8, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
